// File: rtl/regfile_pkg.sv
// Shared types and defaults for the regfile_gen2 register file and its clear sequencer.
package regfile_pkg;

    typedef enum logic {IDLE, CLEAR} clr_state_e;

    localparam int DefaultWidth = 16;
    localparam int DefaultDepth = 8;

endpackage

// File: rtl/regfile_gen2_if.sv
// Bus bundle for regfile_gen2: two read ports, one write port, clear request and status.
interface regfile_gen2_if import regfile_pkg::*; #(
    parameter int WIDTH  = DefaultWidth,
    parameter int ADDR_W = $clog2(DefaultDepth)
);
    logic                     rd_en_a;
    logic [ADDR_W-1:0]        addr_a;
    logic                     rd_en_b;
    logic [ADDR_W-1:0]        addr_b;
    logic                     we;
    logic [ADDR_W-1:0]        waddr;
    logic signed [WIDTH-1:0]  wdata;
    logic                     clr;
    logic signed [WIDTH-1:0]  data_a;
    logic signed [WIDTH-1:0]  data_b;
    logic                     valid_a;
    logic                     valid_b;
    logic                     busy;

    modport master (
        output rd_en_a, addr_a, rd_en_b, addr_b, we, waddr, wdata, clr,
        input  data_a, data_b, valid_a, valid_b, busy
    );

    modport slave (
        input  rd_en_a, addr_a, rd_en_b, addr_b, we, waddr, wdata, clr,
        output data_a, data_b, valid_a, valid_b, busy
    );

endinterface

// File: rtl/regfile_clr_seq.sv
// Clear sweep sequencer: on clr, walks indices 0..DEPTH-1 one per cycle with busy held high.
module regfile_clr_seq import regfile_pkg::*; #(
    parameter int DEPTH  = DefaultDepth,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    output logic              busy,
    output logic [ADDR_W-1:0] clr_addr,
    output logic              clr_stb
);

    localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(DEPTH - 1);

    clr_state_e        state_q;
    logic [ADDR_W-1:0] idx_q;
    logic              busy_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (clr) begin
                        state_q <= CLEAR;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                CLEAR: begin
                    // clr is ignored here; the sweep always runs to completion
                    if (idx_q == LastIdx) begin
                        state_q <= IDLE;
                        idx_q   <= '0;
                        busy_q  <= 1'b0;
                    end else begin
                        idx_q <= idx_q + ADDR_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    idx_q   <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign clr_addr = idx_q;
    assign clr_stb  = (state_q == CLEAR);

endmodule

// File: rtl/regfile_gen2.sv
// Dual-read, single-write register file with 1-cycle registered reads and a clear sweep.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to a matching read.
module regfile_gen2 import regfile_pkg::*; #(
    parameter int WIDTH    = DefaultWidth,
    parameter int DEPTH    = DefaultDepth,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter bit ZERO_REG = 1'b0
) (
    input logic           clk,
    input logic           rst,
    regfile_gen2_if.slave bus
);

    localparam logic [ADDR_W:0] DepthLim = (ADDR_W + 1)'(DEPTH);

    logic signed [WIDTH-1:0] mem_q [DEPTH];
    logic signed [WIDTH-1:0] data_a_q, data_b_q;
    logic signed [WIDTH-1:0] rd_val_a, rd_val_b;
    logic                    valid_a_q, valid_b_q;
    logic                    busy;
    logic [ADDR_W-1:0]       clr_addr;
    logic                    clr_stb;
    logic                    wr_commit;

    // Out-of-range addresses and a hardwired r0 behave identically: read 0, ignore writes.
    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} < DepthLim) && !(ZERO_REG && (a == '0));
    endfunction

    regfile_clr_seq #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_clr_seq (
        .clk      (clk),
        .rst      (rst),
        .clr      (bus.clr),
        .busy     (busy),
        .clr_addr (clr_addr),
        .clr_stb  (clr_stb)
    );

    assign wr_commit = bus.we && !busy && !bus.clr && addr_ok(bus.waddr);

    always_comb begin
        rd_val_a = '0;
        rd_val_b = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (addr_ok(bus.addr_a) && (bus.addr_a == ADDR_W'(i))) rd_val_a = mem_q[i];
            if (addr_ok(bus.addr_b) && (bus.addr_b == ADDR_W'(i))) rd_val_b = mem_q[i];
        end
`ifdef REGFILE_BYPASS_EN
        if (wr_commit && (bus.addr_a == bus.waddr)) rd_val_a = bus.wdata;
        if (wr_commit && (bus.addr_b == bus.waddr)) rd_val_b = bus.wdata;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (clr_stb && (clr_addr == ADDR_W'(i))) begin
                    mem_q[i] <= '0;
                end else if (wr_commit && (bus.waddr == ADDR_W'(i))) begin
                    mem_q[i] <= bus.wdata;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_a_q  <= '0;
            data_b_q  <= '0;
            valid_a_q <= 1'b0;
            valid_b_q <= 1'b0;
        end else begin
            valid_a_q <= bus.rd_en_a;
            valid_b_q <= bus.rd_en_b;
            if (bus.rd_en_a) data_a_q <= rd_val_a;
            if (bus.rd_en_b) data_b_q <= rd_val_b;
        end
    end

    assign bus.data_a  = data_a_q;
    assign bus.data_b  = data_b_q;
    assign bus.valid_a = valid_a_q;
    assign bus.valid_b = valid_b_q;
    assign bus.busy    = busy;

endmodule

// File: doc/regfile_gen2.md
REGFILE_GEN2 -- requirements
Module: regfile_gen2

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning signed data width in bits.
REQ-002 SHALL have parameter DEPTH, default 8, meaning number of registers (2..256).
REQ-003 SHALL have parameter ADDR_W, default $clog2(DEPTH), meaning address width.
REQ-004 SHALL have parameter ZERO_REG, default 0, meaning 1 = register 0 hardwired to zero.
REQ-005 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port rd_en_a  input  1  read request, port A.
REQ-008 SHALL have port addr_a  input  ADDR_W  read address, port A.
REQ-009 SHALL have port rd_en_b  input  1  read request, port B.
REQ-010 SHALL have port addr_b  input  ADDR_W  read address, port B.
REQ-011 SHALL have port we  input  1  write enable.
REQ-012 SHALL have port waddr  input  ADDR_W  write address, independent of read addresses.
REQ-013 SHALL have port wdata  input  WIDTH  signed write data.
REQ-014 SHALL have port clr  input  1  single-cycle request to zero all registers.
REQ-015 SHALL have port data_a / data_b  output  WIDTH  signed registered read data.
REQ-016 SHALL have port valid_a / valid_b  output  1  read-data-valid pulses.
REQ-017 SHALL have port busy  output  1  clear sweep in progress.

Function
REQ-018 Reads SHALL have 1-cycle latency: rd_en_x at edge N -> data_x updated and valid_x high for exactly cycle N+1.
REQ-019 data_x SHALL hold its last value while rd_en_x is low; valid_x SHALL be low.
REQ-020 Write SHALL commit at the rising edge when we=1, busy=0, clr=0; otherwise dropped.
REQ-021 Addresses >= DEPTH SHALL read as 0 and ignore writes.
REQ-022 With ZERO_REG=1, writes to address 0 SHALL be ignored and reads of 0 SHALL return 0.
REQ-023 Clear FSM SHALL have states IDLE and CLEAR; IDLE->CLEAR when clr=1; in CLEAR one register per cycle zeroed, index 0..DEPTH-1; CLEAR->IDLE after index DEPTH-1 written.
REQ-024 busy SHALL be high for exactly DEPTH cycles, starting the cycle after clr is sampled.
REQ-025 clr SHALL have priority over we in the same cycle; clr during CLEAR SHALL be ignored.
REQ-026 Reads during CLEAR SHALL still be served, returning current (partially cleared) contents.
REQ-027 Same-cycle read and write to one address SHALL follow REQ-031/REQ-032.

Reset
REQ-028 rst=1 SHALL immediately zero all registers, data_a, data_b, valid_a, valid_b, busy, sweep index, and force IDLE.
REQ-029 rst asserted mid-CLEAR SHALL abort the sweep; no resumption after release.
REQ-030 First edge after rst deassertion SHALL operate normally.

Configuration
REQ-031 With REGFILE_BYPASS_EN defined, a read whose address equals waddr while a write commits SHALL return wdata.
REQ-032 Without REGFILE_BYPASS_EN, that read SHALL return the pre-write value; new value visible from the next read.

Structure
REQ-033 Package regfile_pkg SHALL hold the FSM state typedef (IDLE, CLEAR) and default WIDTH/DEPTH constants.
REQ-034 Sweep FSM and index counter SHALL be a sub-module regfile_clr_seq outputting busy, clear address, clear strobe.

Verification
REQ-035 Write 0x7FFF to r3, then rd_en_a addr 3 -> data_a=0x7FFF, valid_a high one cycle later.
REQ-036 Same-cycle we r5=-2 and rd_en_b addr 5 (r5 was 9) -> data_b=-2 with bypass, 9 without.
REQ-037 Fill r0..r7 with 1..8, pulse clr -> busy high 8 cycles, all reads 0 afterwards, we during busy dropped.
REQ-038 ZERO_REG=1: write 0x1234 to r0 -> read r0 returns 0.
REQ-039 Assert rst at sweep index 4 -> all outputs 0, busy low immediately, later write/read r2=0x55 returns 0x55.
REQ-040 DEPTH=6: write addr 7 then read addr 7 -> data 0, r0..r5 unchanged.
